cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit carry-lookahead adder.
- Splits a WIDTH-bit add/subtract into GROUP-bit lookahead groups, one group per pipeline stage; group carries ripple stage-to-stage through registers.
- Sits between operand-producing logic and result consumers, using a valid/ready handshake with full backpressure.
- Adds subtract mode, signed overflow flag and streaming throughput of one op per cycle.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group and per pipeline stage; the pipeline depth is NG = WIDTH/GROUP.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  stage 1 can accept
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- cin  in  1  carry-in (ignored when sub=1)
- sub  in  1  0: x+y+cin; 1: x-y (x + ~y + 1)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- z  out  WIDTH  sum/difference
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits are cleared, so out_valid = 0 immediately. z, cout and ovf are 0. in_ready = 1 once rst_n is high.
- Global advance: en = out_ready | ~out_valid. in_ready = en. All stages shift together when en = 1; every stage holds when en = 0.
- Acceptance: a transfer occurs when in_valid & in_ready. The stage 1 valid bit loads in_valid whenever en = 1, so bubbles propagate as invalid slots.
- Subtract handling is done at entry. Effective operand is yb = sub ? ~y : y. Effective carry-in is c0 = sub ? 1 : cin.
- Stage k (k = 1..NG) works on group k-1, i.e. bits [k*GROUP-1 : (k-1)*GROUP]:
  - It computes per-bit p = a^b and g = a&b.
  - It computes in-group lookahead carries from the registered carry-in of that stage.
  - It computes the group sum and group carry-out, plus the carry into the group MSB, which is used only at the last stage.
- Stage registers carry forward:
  - unconsumed upper operand bits;
  - accumulated lower sum bits;
  - the carry;
  - the valid bit.
- Stage NG registers the final z, cout and ovf.
- Latency: with no stall, a result appears NG cycles after acceptance. A transfer at edge t gives out_valid at edge t+NG.
- Throughput: 1 op per cycle while out_ready = 1.
- Stall: while out_valid & ~out_ready, z, cout, ovf and out_valid hold stable and in_ready = 0. There is no loss and no duplication.
- Simultaneous out transfer and in transfer in the same cycle is allowed; the pipe shifts by one.
- Ordering is strict FIFO.
- Wrap-around: the result is modulo 2^WIDTH, and the carry appears only in cout.
- Reset mid-operation: all in-flight ops are discarded and none is emitted after rst_n rises.
- Outputs are registered; there is no combinational path from x, y or cin to z.
- in_ready depends combinationally on out_ready and the out_valid register only.

Decomposition:
- Shared package cla_pkg holds:
  - a function or localparam for NG = WIDTH/GROUP;
  - a compile-time check that WIDTH % GROUP == 0.
- Sub-module cla_group: purely combinational GROUP-bit lookahead block.
  - Inputs: a, b, ci.
  - Outputs: s, co, and c_msb_in (carry into the group MSB).
  - Uses a P/G generate per bit plus an lookahead carry chain.
- cla_pipe_adder instantiates NG cla_group blocks through a generate loop and owns all registers and handshake logic.

Test Plan:
- WIDTH=16, GROUP=4, out_ready=1: x=0x00FF, y=0x0001, cin=0, sub=0 -> z=0x0100, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance.
- x=0xFFFF, y=0x0001, cin=0 -> z=0x0000, cout=1, ovf=0. Then x=0x7FFF, y=0x0001 -> z=0x8000, cout=0, ovf=1.
- sub=1, x=0x0005, y=0x0007, cin=1 (ignored) -> z=0xFFFE, cout=0, ovf=0. Then sub=1, x=0x8000, y=0x0001 -> z=0x7FFF, cout=1, ovf=1.
- 8 back-to-back ops, with out_ready held low for 3 cycles mid-stream:
  - in_ready drops while stalled;
  - z holds stable during the stall;
  - all 8 results emerge in order with none lost or duplicated;
  - a scoreboard matches x±y.
- 3 ops in flight, then rst_n pulsed low asynchronously mid-cycle -> out_valid falls immediately; no result appears after release; a new op completes with latency 4.
- Reconfigure WIDTH=8, GROUP=8 (NG=1): x=0xF0, y=0x10 -> z=0x00, cout=1, latency 1 cycle.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder: stage count and
// parameter legality check.
package cla_pkg;

    function automatic int unsigned num_groups(input int unsigned width,
                                               input int unsigned group);
        return width / group;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned group);
        return (group != 0) && (width >= group) && ((width % group) == 0);
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead block: per-bit propagate/generate
// and a flattened lookahead carry for every bit position.
module cla_group
    import cla_pkg::*;
#(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             ci_i,
    output logic [GROUP-1:0] s_o,
    output logic             co_o,
    output logic             c_msb_o
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // c[i+1] = G[i:0] | P[i:0] & ci, so every carry depends on ci through one AND-OR
    always_comb begin
        logic gg;
        logic pp;
        gg   = 1'b0;
        pp   = 1'b1;
        c    = '0;
        c[0] = ci_i;
        for (int i = 0; i < GROUP; i++) begin
            gg       = g[i] | (p[i] & gg);
            pp       = pp & p[i];
            c[i+1]   = gg | (pp & ci_i);
        end
    end

    assign s_o     = p ^ c[GROUP-1:0];
    assign co_o    = c[GROUP];
    assign c_msb_o = c[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined add/subtract: one lookahead group per stage, group carries ripple
// through registers, single global enable gives valid/ready backpressure.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] z_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int unsigned NG = num_groups(WIDTH, GROUP);

    if (!params_ok(WIDTH, GROUP)) begin : g_param_check
        $error("cla_pipe_adder: WIDTH must be a nonzero multiple of GROUP");
    end

    logic             en;
    logic             out_valid_q;
    logic [WIDTH-1:0] z_q;
    logic             cout_q;
    logic             ovf_q;

    assign en         = out_ready_i | ~out_valid_q;
    assign in_ready_o = en;

    // Stage k holds the operand bits not yet consumed and the sum bits already produced.
    for (genvar k = 0; k < NG; k++) begin : g_stage
        localparam int unsigned Lo = k * GROUP;

        logic                v_q;
        logic                c_q;
        logic [WIDTH-1:Lo]   a_q;
        logic [WIDTH-1:Lo]   b_q;
        logic [GROUP-1:0]    s;
        logic                co;
        logic                cm;
        logic [Lo+GROUP-1:0] lo;

        cla_group #(
            .GROUP(GROUP)
        ) u_group (
            .a_i    (a_q[Lo+GROUP-1:Lo]),
            .b_i    (b_q[Lo+GROUP-1:Lo]),
            .ci_i   (c_q),
            .s_o    (s),
            .co_o   (co),
            .c_msb_o(cm)
        );

        if (k == 0) begin : g_entry
            assign lo = s;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    v_q <= in_valid_i;
                    if (in_valid_i) begin
                        a_q <= x_i;
                        b_q <= sub_i ? ~y_i : y_i;
                        c_q <= sub_i | cin_i;
                    end
                end
            end
        end else begin : g_body
            logic [Lo-1:0] sum_q;

            assign lo = {s, sum_q};

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    v_q   <= 1'b0;
                    c_q   <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                    sum_q <= '0;
                end else if (en) begin
                    v_q <= g_stage[k-1].v_q;
                    if (g_stage[k-1].v_q) begin
                        a_q   <= g_stage[k-1].a_q[WIDTH-1:Lo];
                        b_q   <= g_stage[k-1].b_q[WIDTH-1:Lo];
                        c_q   <= g_stage[k-1].co;
                        sum_q <= g_stage[k-1].lo;
                    end
                end
            end
        end

        // Carry into the group MSB only matters for overflow at the top group.
        if (k != NG - 1) begin : g_mid
            logic unused_cm;
            assign unused_cm = cm;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            z_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            out_valid_q <= g_stage[NG-1].v_q;
            if (g_stage[NG-1].v_q) begin
                z_q    <= g_stage[NG-1].lo;
                cout_q <= g_stage[NG-1].co;
                ovf_q  <= g_stage[NG-1].co ^ g_stage[NG-1].cm;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign z_o         = z_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (16/4 pipe plus an 8/8 single-stage copy).
module tb_cla_pipe_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] x, y, z;
    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  x8, y8, z8;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .x_i(x), .y_i(y), .cin_i(cin), .sub_i(sub), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .z_o(z), .cout_o(cout), .ovf_o(ovf)
    );

    cla_pipe_adder #(.WIDTH(8), .GROUP(8)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid8), .in_ready_o(in_ready8),
        .x_i(x8), .y_i(y8), .cin_i(cin8), .sub_i(sub8), .out_valid_o(out_valid8),
        .out_ready_i(out_ready8), .z_o(z8), .cout_o(cout8), .ovf_o(ovf8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] z;
        logic        c;
        logic        v;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_out   = 0;
    int          n_stall = 0;
    bit          prev_stall = 1'b0;
    bit          rnd_ready  = 1'b0;
    logic [18:0] held;

    task automatic check(input string name, input bit ok, input longint unsigned act,
                         input longint unsigned req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic void model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                  input logic ci, input logic s, output logic [31:0] zr,
                                  output logic co, output logic ov);
        longint m, half, ua, ub, sa, sb, u, r;
        m    = longint'(1) << w;
        half = m >> 1;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        if (s) begin
            u  = ua - ub;
            r  = sa - sb;
            co = (ua >= ub);
        end else begin
            u  = ua + ub + longint'(ci);
            r  = sa + sb + longint'(ci);
            co = (u >= m);
        end
        zr = 32'((u + m) % m);
        ov = (r >= half) || (r < -half);
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic s, input bit lat);
        exp_t        e;
        logic [31:0] zr;
        logic        co, ov;
        bit          ok;
        ok = 1'b0;
        model(16, {16'h0, a}, {16'h0, b}, ci, s, zr, co, ov);
        e.z = zr[15:0];
        e.c = co;
        e.v = ov;
        e.lat = lat;
        in_valid = 1'b1;
        x = a; y = b; cin = ci; sub = s;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            e.acc = cyc + 1;
            exp_q.push_back(e);
        end else begin
            check("accept_timeout", 1'b0, 64'(0), 64'(1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size() == 0, 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic s);
        logic [31:0] zr;
        logic        co, ov;
        bit          ok;
        ok = 1'b0;
        model(8, {24'h0, a}, {24'h0, b}, ci, s, zr, co, ov);
        in_valid8 = 1'b1;
        x8 = a; y8 = b; cin8 = ci; sub8 = s;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready8) begin
                ok = 1'b1;
                break;
            end
        end
        check("w8_accept", ok, 64'(ok), 64'(1));
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        check("w8_not_early", out_valid8 == 1'b0, 64'(out_valid8), 64'(0));
        @(negedge clk);
        check("w8_valid", out_valid8 == 1'b1, 64'(out_valid8), 64'(1));
        check("w8_result", {z8, cout8, ovf8} == {zr[7:0], co, ov},
              64'({z8, cout8, ovf8}), 64'({zr[7:0], co, ov}));
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer, checks stall behaviour.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold", {out_valid, z, cout, ovf} == held,
                          64'({out_valid, z, cout, ovf}), 64'(held));
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 1'b0, 64'({z, cout, ovf}), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {z, cout, ovf} == {e.z, e.c, e.v},
                              64'({z, cout, ovf}), 64'({e.z, e.c, e.v}));
                        if (e.lat) check("latency", (cyc - e.acc) == 4,
                                         64'(cyc - e.acc), 64'(4));
                    end
                end
                if (out_valid && !out_ready) begin
                    n_stall++;
                    check("in_ready_stall", in_ready == 1'b0, 64'(in_ready), 64'(0));
                    prev_stall = 1'b1;
                    held = {out_valid, z, cout, ovf};
                end else begin
                    prev_stall = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int n0;
        in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; x8 = '0; y8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;

        #2 rst_n = 1'b0;
        #1;
        check("reset_out_valid", out_valid == 1'b0, 64'(out_valid), 64'(0));
        check("reset_z", z == 16'h0, 64'(z), 64'(0));
        check("reset_flags", {cout, ovf} == 2'b00, 64'({cout, ovf}), 64'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("reset_in_ready", in_ready == 1'b1, 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Directed cases and boundaries
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
        drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        drain();
        send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        send(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        send(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1);
        send(16'h0000, 16'h8000, 1'b0, 1'b1, 1'b1);
        drain();

        // 8 back-to-back with a 3-cycle stall in the middle
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_seen", n_stall >= 3, 64'(n_stall), 64'(3));

        // Random traffic under random backpressure
        rnd_ready = 1'b1;
        repeat (40) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        drain();
        rnd_ready = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Fill the pipe, then reset asynchronously mid-cycle
        out_ready = 1'b0;
        repeat (5) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        check("pre_reset_valid", out_valid == 1'b1, 64'(out_valid), 64'(1));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_clear_valid", out_valid == 1'b0, 64'(out_valid), 64'(0));
        check("async_clear_z", z == 16'h0, 64'(z), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        n0 = n_out;
        repeat (12) @(posedge clk);
        #1;
        check("no_ghost", n_out == n0, 64'(n_out - n0), 64'(0));
        send(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
        drain();

        // Single-stage configuration
        send8(8'hF0, 8'h10, 1'b0, 1'b0);
        repeat (4) send8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
